mips_multicycle_core: RTL
=========================

# mips_multicycle_core

Multi-cycle MIPS32 core: the next generation of the single-cycle datapath. It executes the same instruction subset (add, addi, lw, sw, sll, and, andi, nor, beq, jal, jr, slt) through a control state machine. The core fetches and accesses data over one shared memory port with a ready handshake, so instruction and data memory may have arbitrary wait states. It contains its own register file and datapath registers (IR, MDR, A, B, ALUOut) and exposes a write-back trace for verification.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- mem_req  out  1  memory access request, held until accepted
- mem_we  out  1  1 = write (sw), 0 = read (fetch, lw); valid while mem_req
- mem_addr  out  32  byte address, always word aligned when mem_req=1
- mem_wdata  out  32  store data, valid while mem_req && mem_we
- mem_rdata  in  32  read data, sampled on the cycle mem_req && mem_ready
- mem_ready  in  1  access completes on a cycle where mem_req && mem_ready
- pc  out  32  address of the instruction in progress
- retire  out  1  one-cycle pulse in the final cycle of every instruction
- wb_we  out  1  register-file write this cycle (never for $0)
- wb_addr  out  5  destination register of that write
- wb_data  out  32  data written
- illegal  out  1  sticky flag: unsupported opcode/funct or misaligned lw/sw seen

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Reset (async): state=IDLE, pc=RESET_PC, all 32 registers=0, IR/MDR/A/B/ALUOut=0, illegal=0. All outputs are 0 except pc.
- IDLE: the state after reset. Go to FETCH unconditionally on the next clock.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: IR<=mem_rdata and go to DECODE. Otherwise stay in FETCH.
- DECODE: A<=R[rs], B<=R[rt], ALUOut<=pc+4+(sext(imm)<<2). Unsupported encodings set illegal, pc<=pc+4, retire, and return to FETCH.
- EXEC by class:
  - R-type (add, and, nor, slt, sll): ALUOut<=result, then WB.
  - addi/andi: addi sign-extends imm; andi zero-extends it. ALUOut<=result, then WB.
  - lw/sw: ALUOut<=A+sext(imm), then MEM. If the address has [1:0]≠0: set illegal, pc<=pc+4, retire, then FETCH.
  - beq: if A==B, pc<=ALUOut; else pc<=pc+4. Retire, then FETCH.
  - jal: R[31]<=pc+4, pc<={pc+4[31:28],target,2'b00}. Retire, then FETCH.
  - jr: pc<=A. Retire, then FETCH.
- MEM: mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B.
  - lw: on ready, MDR<=mem_rdata, then WB.
  - sw: on ready, pc<=pc+4, retire, then FETCH.
- WB: R[dest]<=value, pc<=pc+4, retire, then FETCH.
  - dest is rd for R-type and rt for I-type.
  - value is MDR for lw, ALUOut otherwise.
- Arithmetic: 32-bit wrap-around with no overflow trap. slt is a signed compare. sll shifts rt by shamt. nor is ~(A|B).
- $0: reads return 0. Writes to $0 are dropped, and wb_we stays 0 (retire still pulses).
- Register reads in DECODE see every write completed in earlier cycles; there is no forwarding within a cycle.

## Timing
- Cycle counts with zero-wait memory (mem_ready tied 1):
  - beq, jal, jr: 3 cycles.
  - R-type, addi, andi, sw: 4 cycles.
  - lw: 5 cycles.
- Each memory wait cycle adds exactly one cycle to FETCH or MEM.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from the first request cycle through the accept cycle.
- mem_req is low in IDLE, DECODE, EXEC and WB.
- retire, wb_we, wb_addr and wb_data are combinational from the final state.
  - wb_we is 1 only in WB, and in EXEC for jal (addr 31).
  - retire is high for exactly one cycle per instruction.
- pc updates on the clock edge that ends the retiring cycle.
- First fetch request: the second cycle after reset_n rises (the first cycle is IDLE).
- Reset asserted mid-access drops mem_req immediately and asynchronously. The abandoned access is never retried; execution restarts at RESET_PC.
- illegal, once set, stays set until reset.

## Test plan
- Arithmetic sequence, zero-wait memory:
  - Stimulus: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; nor $5,$0,$0; sll $6,$1,4.
  - Expected wb trace: $1=5, $2=0xFFFFFFFD, $3=2, $4=1, $5=0xFFFFFFFF, $6=0x50.
  - Each instruction retires 4 cycles after the previous one.
- Memory with wait states (ready low for 3 cycles on every access):
  - Stimulus: sw $1,8($0), then lw $7,8($0).
  - Expected: write with mem_addr=8, mem_wdata=5, followed by wb $7=5.
  - Request signals stay stable throughout each wait.
  - lw takes 5+6 cycles.
- Control flow:
  - beq taken from pc 0x10 with imm=2 → next fetch at 0x1C; not-taken → 0x14.
  - jal at 0x20 with target=0x40 → wb $31=0x24, next fetch 0x100.
  - jr $31 → fetch 0x24.
- $0 protection and andi: add $0,$1,$1 → retire with wb_we=0, and $0 still reads 0. andi $8,$2,0xFFFF → $8=0x0000FFFD.
- Errors:
  - Unsupported opcode 0x3F at pc 0x30 → illegal=1, retire, next fetch 0x34.
  - lw $9,2($0) → illegal, no mem_req, $9 unchanged.
- Reset mid-MEM (ready held low): assert reset_n=0 → mem_req falls the same cycle. After release: IDLE, then fetch at RESET_PC, with all registers and illegal cleared.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// ---------------------------------------------------------------------------
// mips_multicycle_core
//   Multi-cycle MIPS32 core for the subset add, addi, lw, sw, sll, and, andi,
//   nor, beq, jal, jr, slt. Instructions and data share one memory port with
//   a ready handshake, so either access may stall for any number of cycles.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   mem_req / mem_we      access request (held until mem_ready), 1 = store
//   mem_addr / mem_wdata  word-aligned byte address and store data
//   mem_rdata / mem_ready read data and completion strobe from memory
//   pc                    address of the instruction in progress
//   retire                one-cycle pulse in the last cycle of each instruction
//   wb_we/addr/data       register-file write trace (never reports $0)
//   illegal               sticky flag for bad encodings or misaligned lw/sw
// ---------------------------------------------------------------------------
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        retire,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    state_t      state, state_next;
    logic [31:0] ir, mdr, a_reg, b_reg, alu_out;
    logic [31:0] regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, wb_dest;
    logic [31:0] imm_sext, imm_zext, pc_plus4, jump_target, ls_addr;
    logic [31:0] exec_result, wb_value;
    logic        is_rtype_alu, is_jr, is_addi, is_andi, is_lw, is_sw;
    logic        is_beq, is_jal, legal, misaligned, writes_back;

    // Instruction fields and class flags all come straight from IR, which is
    // stable from DECODE until the instruction retires.
    assign opcode      = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign shamt       = ir[10:6];
    assign funct       = ir[5:0];
    assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext    = {16'h0000, ir[15:0]};
    assign pc_plus4    = pc + 32'd4;
    assign jump_target = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign ls_addr     = a_reg + imm_sext;
    assign misaligned  = (ls_addr[1:0] != 2'b00);

    assign is_rtype_alu = (opcode == OP_RTYPE) &&
                          (funct == FN_ADD || funct == FN_AND || funct == FN_NOR ||
                           funct == FN_SLT || funct == FN_SLL);
    assign is_jr       = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign is_addi     = (opcode == OP_ADDI);
    assign is_andi     = (opcode == OP_ANDI);
    assign is_lw       = (opcode == OP_LW);
    assign is_sw       = (opcode == OP_SW);
    assign is_beq      = (opcode == OP_BEQ);
    assign is_jal      = (opcode == OP_JAL);
    assign legal       = is_rtype_alu | is_jr | is_addi | is_andi | is_lw | is_sw | is_beq | is_jal;
    assign writes_back = is_rtype_alu | is_addi | is_andi;

    assign wb_dest  = (opcode == OP_RTYPE) ? rd : rt;
    assign wb_value = is_lw ? mdr : alu_out;

    // EXEC-stage ALU. addi and the lw/sw address share the sign-extended add,
    // so that is the default result; andi is the only zero-extended operand.
    always_comb begin
        exec_result = ls_addr;
        if (is_rtype_alu) begin
            case (funct)
                FN_ADD:  exec_result = a_reg + b_reg;
                FN_AND:  exec_result = a_reg & b_reg;
                FN_NOR:  exec_result = ~(a_reg | b_reg);
                FN_SLT:  exec_result = {31'b0, $signed(a_reg) < $signed(b_reg)};
                FN_SLL:  exec_result = b_reg << shamt;
                default: exec_result = a_reg + b_reg;
            endcase
        end else if (is_andi) begin
            exec_result = a_reg & imm_zext;
        end
    end

    // Control state register. Reset drops straight to IDLE, which also kills
    // any outstanding memory request without retrying it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: memory states wait on mem_ready, everything that
    // retires early (bad encodings, branches, jumps, misaligned lw/sw, sw)
    // heads back to FETCH.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   state_next = FETCH;
            FETCH:  if (mem_ready) state_next = DECODE;
            DECODE: state_next = legal ? EXEC : FETCH;
            EXEC: begin
                if (writes_back)                 state_next = WB;
                else if ((is_lw || is_sw) && !misaligned) state_next = MEM;
                else                             state_next = FETCH;
            end
            MEM:    if (mem_ready) state_next = is_lw ? WB : FETCH;
            WB:     state_next = FETCH;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the current state only, so the memory request is
    // naturally stable for as long as the core sits in FETCH or MEM, and the
    // write-back trace lines up with the cycle the register file is written.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        retire    = 1'b0;
        wb_we     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            DECODE: retire = !legal;
            EXEC: begin
                retire = is_beq | is_jal | is_jr | ((is_lw | is_sw) & misaligned);
                if (is_jal) begin
                    wb_we   = 1'b1;
                    wb_addr = 5'd31;
                    wb_data = pc_plus4;
                end
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_sw;
                mem_addr  = alu_out;
                mem_wdata = is_sw ? b_reg : 32'h0;
                retire    = is_sw & mem_ready;
            end
            WB: begin
                retire = 1'b1;
                if (wb_dest != 5'd0) begin
                    wb_we   = 1'b1;
                    wb_addr = wb_dest;
                    wb_data = wb_value;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers and register file. DECODE precomputes the branch
    // target into ALUOut so beq can resolve in EXEC; $0 is never written, so
    // it keeps reading as zero without a read-side special case.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            ir      <= 32'h0;
            mdr     <= 32'h0;
            a_reg   <= 32'h0;
            b_reg   <= 32'h0;
            alu_out <= 32'h0;
            illegal <= 1'b0;
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
        end else begin
            case (state)
                FETCH: if (mem_ready) ir <= mem_rdata;
                DECODE: begin
                    a_reg   <= regs[rs];
                    b_reg   <= regs[rt];
                    alu_out <= pc_plus4 + (imm_sext << 2);
                    if (!legal) begin
                        illegal <= 1'b1;
                        pc      <= pc_plus4;
                    end
                end
                EXEC: begin
                    if (writes_back || is_lw || is_sw) alu_out <= exec_result;
                    if ((is_lw || is_sw) && misaligned) begin
                        illegal <= 1'b1;
                        pc      <= pc_plus4;
                    end
                    if (is_beq) pc <= (a_reg == b_reg) ? alu_out : pc_plus4;
                    if (is_jal) begin
                        regs[31] <= pc_plus4;
                        pc       <= jump_target;
                    end
                    if (is_jr) pc <= a_reg;
                end
                MEM: begin
                    if (mem_ready) begin
                        if (is_lw) mdr <= mem_rdata;
                        else       pc  <= pc_plus4;
                    end
                end
                WB: begin
                    if (wb_dest != 5'd0) regs[wb_dest] <= wb_value;
                    pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end

endmodule
